rede_io_sched: RTL and testbench
================================

// Module: rede_io_sched
// PURPOSE
//  Frame-level I/O sequencer between the proc_fx core and external sample streams.
//  Packs an inbound valid/ready sample stream into double-buffered input frames.
//  Serves these frames to the core on its decoded req_in strobes.
//  Captures core results on its decoded out_en strobes and drains each result frame
//  to an outbound valid/ready stream.
//  Holds the core in reset until the first input frame is complete.
// PARAMETERS
//  NUBITS   31  data word width (signed fixed point, as proc_fx)
//  NUIOIN   4   number of core input ports (width of req_in)
//  NUIOOU   4   number of core output ports (width of out_en)
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous, active-low reset
//  s_data     in   NUBITS  inbound sample; port order 0..NUIOIN-1 per frame
//  s_valid    in   1       inbound sample valid
//  s_ready    out  1       inbound sample accepted when s_valid&s_ready
//  m_data     out  NUBITS  outbound result; port order 0..NUIOOU-1 per frame
//  m_valid    out  1       outbound result valid
//  m_ready    in   1       outbound sink ready
//  proc_hold  out  1       active-high reset/hold to proc_fx
//  io_in      out  NUBITS  data to proc_fx io_in
//  req_in     in   NUIOIN  one-hot read strobe from the addr_dec input decoder
//  io_out     in   NUBITS  data from proc_fx io_out
//  out_en     in   NUIOOU  one-hot write strobe from the addr_dec output decoder
//  underrun   out  1       sticky: core finished a frame before the next input frame was ready
//  overrun    out  1       sticky: result frame completed while the previous one was still draining
//  frame_cnt  out  16      count of input frames swapped into the active bank (wraps)
// BEHAVIOUR
//  Reset (rst=0, async): proc_hold=1, s_ready=1, m_valid=0, m_data=0, io_in=0,
//   underrun=0, overrun=0, frame_cnt=0, all banks 0, fill index 0.
//   Input FSM enters BOOT; output FSM enters COLLECT.
//  Input FSM {BOOT, FILL, FULL}; banks A (active) and S (shadow), NUIOIN words each.
//   BOOT: accepted samples fill S[idx], idx++.
//    Acceptance of word NUIOIN-1 -> S copied to A, idx=0, frame_cnt=1.
//    Next cycle proc_hold=0 -> FILL.
//   FILL: accepted sample -> S[idx], idx++. Last word -> FULL, and s_ready=0 from the next cycle.
//   FULL: s_ready=0; wait for swap.
//   Swap: at an edge with req_in[NUIOIN-1]=1 and state FULL (or last word accepted
//    that same edge): A<=S (including that word), idx=0, frame_cnt++ -> FILL.
//   Swap with S not full: no swap; A is reused and underrun<=1. S keeps its partial fill.
//  io_in: combinational from A[k] when req_in[k]=1 (zero-latency, same cycle as strobe).
//   io_in=0 when req_in=0. A non-one-hot req_in is a protocol error; io_in=0 in that case.
//  Output FSM {COLLECT, DRAIN}; capture bank C and drain bank D.
//   Any state: at an edge with out_en[k]=1, C[k]<=io_out.
//   out_en[NUIOOU-1] with state COLLECT: D<=C (with the same-edge word), oidx=0 -> DRAIN.
//   out_en[NUIOOU-1] with state DRAIN: overrun<=1; that result frame is dropped (D untouched).
//   DRAIN: m_valid=1, m_data=D[oidx], registered outputs.
//    Each m_valid&m_ready advances oidx.
//    Handshake on oidx=NUIOOU-1 -> COLLECT, and m_valid=0 from the next cycle.
//   m_data is held stable while m_valid=1 and m_ready=0.
//  Data passes unmodified; no width change; signed values are transparent.
//  Ports not written in a frame re-emit their previous C value (no flag).
//  frame_cnt wraps 0xFFFF->0. Underrun/overrun clear only on reset.
//  Reset mid-frame: partial frames discarded, proc_hold reasserted, restart in BOOT.
// STRUCTURE
//  Package rede_io_pkg:
//   - input-state and output-state enums
//   - CLOG2 function for the idx/oidx widths
//   - FRAME_CNT_W=16 constant
//  Sub-module rede_bank_buf: NUM x NUBITS register bank with
//   - indexed write enable
//   - bulk copy-in
//   - one-hot read mux
//  The top instantiates it four times, for banks A, S, C and D.
//  Input and output FSMs are independent always blocks in the top.
// TESTING (NUBITS=31, NUIOIN=NUIOOU=4)
//  1 Boot: stream 1,2,3,4 with s_valid=1 -> proc_hold falls 1 cycle after 4th accept;
//    req_in=0001..1000 yields io_in 1,2,3,4; frame_cnt=1.
//  2 Swap: stream 5..8, then req_in=1000 -> next req_in=0001 yields 5; frame_cnt=2; s_ready back to 1.
//  3 Underrun: only 9,10 streamed before req_in=1000 -> underrun=1, next req_in=0001 yields 5;
//    streaming 11,12 then a swap gives 9.
//  4 Drain: out_en 0001..1000 with io_out -7,8,-9,10, m_ready=1 -> m_data -7,8,-9,10 on 4
//    consecutive cycles, then m_valid=0.
//  5 Backpressure/overrun: m_ready=0 during drain while a second out_en frame completes ->
//    overrun=1; m_data holds -7 until m_ready=1, and the second frame is never emitted.
//  6 Async reset: drop rst mid-DRAIN/FILL -> outputs reach reset values without a clock edge;
//    test 1 then passes again.

Source files
------------

// File: rtl/rede_io_sched_pkg.sv
// Shared types and constants for the rede_io_sched frame sequencer.
package rede_io_pkg;

  localparam int unsigned FRAME_CNT_W = 16;

  typedef enum logic [1:0] {
    IN_BOOT,
    IN_FILL,
    IN_FULL
  } in_state_e;

  typedef enum logic {
    OUT_COLLECT,
    OUT_DRAIN
  } out_state_e;

  // Index width for an n-entry bank, never narrower than one bit.
  function automatic int unsigned CLOG2(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

endpackage

// File: rtl/rede_io_sched_if.sv
// Inbound and outbound valid/ready sample streams of rede_io_sched.
interface rede_io_sched_if #(
  parameter int unsigned NUBITS = 31
) ();

  logic [NUBITS-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [NUBITS-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );

endinterface

// File: rtl/rede_bank_buf.sv
// NUM x NUBITS register bank: per-word write mask, bulk copy-in, one-hot read mux.
module rede_bank_buf #(
  parameter int unsigned NUM    = 4,
  parameter int unsigned NUBITS = 31
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM-1:0]        wr_mask,
  input  logic [NUBITS-1:0]     wr_data,
  input  logic                  load,
  input  logic [NUM*NUBITS-1:0] load_data,
  input  logic [NUM-1:0]        rd_sel,
  output logic [NUBITS-1:0]     rd_data,
  output logic [NUM*NUBITS-1:0] q
);

  // A masked write wins over a same-edge bulk copy so a word arriving on the
  // copy edge lands in the destination.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM; k++) begin
        if (wr_mask[k])
          q[k*NUBITS +: NUBITS] <= wr_data;
        else if (load)
          q[k*NUBITS +: NUBITS] <= load_data[k*NUBITS +: NUBITS];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if ($onehot(rd_sel)) begin
      for (int unsigned k = 0; k < NUM; k++) begin
        if (rd_sel[k]) rd_data = q[k*NUBITS +: NUBITS];
      end
    end
  end

endmodule

// File: rtl/rede_io_sched.sv
// Frame-level I/O sequencer: packs inbound samples into double-buffered frames for
// proc_fx, and captures its result frames for draining to the outbound stream.
module rede_io_sched
  import rede_io_pkg::*;
#(
  parameter int unsigned NUBITS = 31,
  parameter int unsigned NUIOIN = 4,
  parameter int unsigned NUIOOU = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rede_io_sched_if.slave         strm,
  output logic                   proc_hold,
  output logic [NUBITS-1:0]      io_in,
  input  logic [NUIOIN-1:0]      req_in,
  input  logic [NUBITS-1:0]      io_out,
  input  logic [NUIOOU-1:0]      out_en,
  output logic                   underrun,
  output logic                   overrun,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned IDX_W  = CLOG2(NUIOIN);
  localparam int unsigned OIDX_W = CLOG2(NUIOOU);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUIOIN - 1);
  localparam logic [OIDX_W-1:0] OIDX_LAST = OIDX_W'(NUIOOU - 1);

  // ---------------- input side: banks S (shadow) and A (active) ----------------
  in_state_e                in_state;
  logic [IDX_W-1:0]         idx;
  logic                     accept, last_acc, swap_req, a_load;
  logic [NUIOIN-1:0]        s_wr_mask, a_wr_mask;
  logic [NUIOIN*NUBITS-1:0] s_q, a_q_unused;
  logic [NUBITS-1:0]        s_rd_unused;

  assign accept    = strm.s_valid & strm.s_ready;
  assign last_acc  = accept && (idx == IDX_LAST);
  assign swap_req  = req_in[NUIOIN-1] && (in_state != IN_BOOT);
  assign a_load    = (in_state == IN_BOOT && last_acc) ||
                     (swap_req && (in_state == IN_FULL || last_acc));
  assign a_wr_mask = a_load ? s_wr_mask : '0;

  always_comb begin
    s_wr_mask = '0;
    if (accept) s_wr_mask[idx] = 1'b1;
  end

  rede_bank_buf #(.NUM(NUIOIN), .NUBITS(NUBITS)) u_bank_s (
    .clk(clk), .rst_n(rst),
    .wr_mask(s_wr_mask), .wr_data(strm.s_data),
    .load(1'b0), .load_data('0),
    .rd_sel('0), .rd_data(s_rd_unused), .q(s_q)
  );

  rede_bank_buf #(.NUM(NUIOIN), .NUBITS(NUBITS)) u_bank_a (
    .clk(clk), .rst_n(rst),
    .wr_mask(a_wr_mask), .wr_data(strm.s_data),
    .load(a_load), .load_data(s_q),
    .rd_sel(req_in), .rd_data(io_in), .q(a_q_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state     <= IN_BOOT;
      idx          <= '0;
      frame_cnt    <= '0;
      proc_hold    <= 1'b1;
      strm.s_ready <= 1'b1;
      underrun     <= 1'b0;
    end else begin
      if (accept) idx <= last_acc ? '0 : idx + 1'b1;
      if (a_load) frame_cnt <= frame_cnt + 1'b1;
      case (in_state)
        IN_BOOT: begin
          if (last_acc) begin
            proc_hold <= 1'b0;
            in_state  <= IN_FILL;
          end
        end
        IN_FILL: begin
          // A swap racing the last word is a clean swap; any other swap in FILL underruns.
          if (swap_req && !last_acc) begin
            underrun <= 1'b1;
          end else if (last_acc && !swap_req) begin
            in_state     <= IN_FULL;
            strm.s_ready <= 1'b0;
          end
        end
        IN_FULL: begin
          if (swap_req) begin
            in_state     <= IN_FILL;
            strm.s_ready <= 1'b1;
          end
        end
        default: in_state <= IN_BOOT;
      endcase
    end
  end

  // ---------------- output side: banks C (capture) and D (drain) ----------------
  out_state_e               out_state;
  logic [OIDX_W-1:0]        oidx;
  logic                     d_load, m_fire;
  logic [NUIOOU-1:0]        d_sel;
  logic [NUBITS-1:0]        c_rd0, c0_next, d_rd;
  logic [NUIOOU*NUBITS-1:0] c_q, d_q_unused;

  assign d_load  = out_en[NUIOOU-1] && (out_state == OUT_COLLECT);
  assign m_fire  = strm.m_valid & strm.m_ready;
  assign c0_next = out_en[0] ? io_out : c_rd0;

  // d_sel looks one word ahead so m_data can be registered on each handshake.
  always_comb begin
    d_sel = '0;
    for (int unsigned k = 0; k < NUIOOU; k++) begin
      if (k == 32'(oidx) + 32'd1) d_sel[k] = 1'b1;
    end
  end

  rede_bank_buf #(.NUM(NUIOOU), .NUBITS(NUBITS)) u_bank_c (
    .clk(clk), .rst_n(rst),
    .wr_mask(out_en), .wr_data(io_out),
    .load(1'b0), .load_data('0),
    .rd_sel(NUIOOU'(1)), .rd_data(c_rd0), .q(c_q)
  );

  rede_bank_buf #(.NUM(NUIOOU), .NUBITS(NUBITS)) u_bank_d (
    .clk(clk), .rst_n(rst),
    .wr_mask(d_load ? out_en : '0), .wr_data(io_out),
    .load(d_load), .load_data(c_q),
    .rd_sel(d_sel), .rd_data(d_rd), .q(d_q_unused)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_state    <= OUT_COLLECT;
      oidx         <= '0;
      strm.m_valid <= 1'b0;
      strm.m_data  <= '0;
      overrun      <= 1'b0;
    end else begin
      case (out_state)
        OUT_COLLECT: begin
          if (d_load) begin
            out_state    <= OUT_DRAIN;
            oidx         <= '0;
            strm.m_valid <= 1'b1;
            strm.m_data  <= c0_next;
          end
        end
        OUT_DRAIN: begin
          if (out_en[NUIOOU-1]) overrun <= 1'b1;
          if (m_fire) begin
            if (oidx == OIDX_LAST) begin
              out_state    <= OUT_COLLECT;
              strm.m_valid <= 1'b0;
              strm.m_data  <= '0;
            end else begin
              oidx        <= oidx + 1'b1;
              strm.m_data <= d_rd;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rede_io_sched.sv
// Directed bench for rede_io_sched: table of req_in->io_in vectors plus stream sequences.
module tb_rede_io_sched;
  import rede_io_pkg::*;

  localparam int unsigned NB = 31;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          proc_hold;
  logic [NB-1:0] io_in;
  logic [3:0]    req_in = '0;
  logic [NB-1:0] io_out = '0;
  logic [3:0]    out_en = '0;
  logic          underrun, overrun;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  rede_io_sched_if #(.NUBITS(NB)) strm ();

  rede_io_sched #(.NUBITS(NB), .NUIOIN(4), .NUIOOU(4)) dut (
    .clk(clk), .rst(rst), .strm(strm.slave),
    .proc_hold(proc_hold), .io_in(io_in), .req_in(req_in),
    .io_out(io_out), .out_en(out_en),
    .underrun(underrun), .overrun(overrun), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [3:0]    req;
    logic [NB-1:0] exp;
  } vec_t;

  vec_t vecs[14];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic logic [NB-1:0] w(input int v);
    return NB'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each vector is held for 1 time unit between edges, so no edge sees req_in[3].
  task automatic apply(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      req_in = vecs[i].req;
      #1;
      chk($sformatf("io_in_vec%0d", i), 32'(io_in), 32'(vecs[i].exp));
    end
    req_in = '0;
  endtask

  task automatic send(input int v);
    logic r, ok;
    ok = 1'b0;
    strm.s_data  = w(v);
    strm.s_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      r = strm.s_ready;
      tick();
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("send_accept_%0d", v), 32'(ok), 32'd1);
    strm.s_valid = 1'b0;
  endtask

  task automatic swap();
    req_in = 4'b1000;
    tick();
    req_in = '0;
  endtask

  task automatic out_frame(input int a, input int b, input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      out_en = 4'(1 << k);
      io_out = w(v[k]);
      tick();
    end
    out_en = '0;
  endtask

  task automatic drain_expect(input int a, input int b, input int c, input int d);
    int v[4];
    v = '{a, b, c, d};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m_valid_w%0d", k), 32'(strm.m_valid), 32'd1);
      chk($sformatf("m_data_w%0d", k), 32'(strm.m_data), 32'(w(v[k])));
      tick();
    end
    chk("m_valid_after_drain", 32'(strm.m_valid), 32'd0);
  endtask

  task automatic boot_test();
    send(1); send(2); send(3);
    chk("proc_hold_before_last", 32'(proc_hold), 32'd1);
    send(4);
    chk("proc_hold_after_boot", 32'(proc_hold), 32'd0);
    chk("frame_cnt_boot", 32'(frame_cnt), 32'd1);
    chk("s_ready_boot", 32'(strm.s_ready), 32'd1);
    apply(0, 5);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_proc_hold"}, 32'(proc_hold), 32'd1);
    chk({tag, "_s_ready"}, 32'(strm.s_ready), 32'd1);
    chk({tag, "_m_valid"}, 32'(strm.m_valid), 32'd0);
    chk({tag, "_m_data"}, 32'(strm.m_data), 32'd0);
    chk({tag, "_io_in"}, 32'(io_in), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0001, w(1)};
    vecs[1]  = '{4'b0010, w(2)};
    vecs[2]  = '{4'b0100, w(3)};
    vecs[3]  = '{4'b1000, w(4)};
    vecs[4]  = '{4'b0000, w(0)};
    vecs[5]  = '{4'b0011, w(0)};
    vecs[6]  = '{4'b0001, w(5)};
    vecs[7]  = '{4'b0010, w(6)};
    vecs[8]  = '{4'b0100, w(7)};
    vecs[9]  = '{4'b1000, w(8)};
    vecs[10] = '{4'b0001, w(9)};
    vecs[11] = '{4'b0100, w(11)};
    vecs[12] = '{4'b1000, w(12)};
    vecs[13] = '{4'b0001, w(0)};

    strm.s_data  = '0;
    strm.s_valid = 1'b0;
    strm.m_ready = 1'b0;

    #12;
    check_reset("reset");
    rst = 1'b1;
    tick();

    // 1: boot
    boot_test();

    // 2: clean swap
    send(5); send(6); send(7); send(8);
    chk("s_ready_full", 32'(strm.s_ready), 32'd0);
    chk("frame_cnt_before_swap", 32'(frame_cnt), 32'd1);
    swap();
    chk("frame_cnt_swap", 32'(frame_cnt), 32'd2);
    chk("s_ready_after_swap", 32'(strm.s_ready), 32'd1);
    chk("underrun_clean", 32'(underrun), 32'd0);
    apply(6, 9);

    // 3: underrun, then completion of the partial frame
    send(9); send(10);
    swap();
    chk("underrun_set", 32'(underrun), 32'd1);
    chk("frame_cnt_underrun", 32'(frame_cnt), 32'd2);
    apply(6, 6);
    send(11); send(12);
    chk("s_ready_full2", 32'(strm.s_ready), 32'd0);
    swap();
    chk("frame_cnt_swap3", 32'(frame_cnt), 32'd3);
    apply(10, 12);

    // 4: drain with sink ready
    strm.m_ready = 1'b1;
    out_frame(-7, 8, -9, 10);
    drain_expect(-7, 8, -9, 10);
    chk("overrun_clean", 32'(overrun), 32'd0);

    // 5: backpressure while a second frame completes
    strm.m_ready = 1'b0;
    out_frame(-7, 8, -9, 10);
    chk("bp_m_valid", 32'(strm.m_valid), 32'd1);
    chk("bp_m_data", 32'(strm.m_data), 32'(w(-7)));
    out_frame(100, 200, 300, 400);
    chk("overrun_set", 32'(overrun), 32'd1);
    chk("bp_m_data_held", 32'(strm.m_data), 32'(w(-7)));
    strm.m_ready = 1'b1;
    drain_expect(-7, 8, -9, 10);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("dropped_frame_c%0d", c), 32'(strm.m_valid), 32'd0);
    end

    // 6: async reset mid-DRAIN and mid-FILL
    strm.m_ready = 1'b0;
    out_frame(1, 2, 3, 4);
    send(13);
    chk("pre_reset_m_valid", 32'(strm.m_valid), 32'd1);
    chk("pre_reset_proc_hold", 32'(proc_hold), 32'd0);
    #3;
    rst = 1'b0;
    #1;
    check_reset("async");
    apply(13, 13);
    #2;
    rst = 1'b1;
    strm.m_ready = 1'b1;
    tick();
    boot_test();
    chk("reboot_m_valid", 32'(strm.m_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
